silife_grid_reader: RTL
=======================

Name: silife_grid_reader

Overview:
- Readout engine for the silife_grid_8x8 cell array: drives the grid's row_select, samples the grid's cells bus, and streams one byte per row out over a valid/ready interface.
- Sits between the grid and a downstream consumer such as a display driver, SPI or UART framer.
- Freezes grid evolution (grid_enable low) for the duration of a scan, so every frame is a coherent snapshot of a single generation.

Parameters:
- ROWS, 8, number of grid rows scanned per frame (power of two, 2..8).
- COLS, 8, width of the grid cells bus and of out_data.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle frame request; sampled only in IDLE.
- abort  input  1  synchronous cancel of the frame in progress.
- busy  output  1  high from the cycle after accepted start until the frame ends.
- done  output  1  one-cycle pulse after the last row handshake; never pulsed on abort.
- grid_enable  output  1  connects to the grid enable; equals !busy.
- row_select  output  $clog2(ROWS)  registered row address to the grid.
- cells  input  COLS  grid row contents; combinational function of row_select.
- out_data  output  COLS  captured row value; bit i = column i.
- out_valid  output  1  out_data holds a valid row.
- out_ready  input  1  consumer accepts the row when out_valid && out_ready.
- out_last  output  1  high together with out_valid for row ROWS-1.

Behaviour:
- Reset values (asserted asynchronously, regardless of clk): state=IDLE, busy=0, done=0, grid_enable=1, row_select=0, out_data=0, out_valid=0, out_last=0.
- IDLE:
  - start=1 at edge N: state becomes SETTLE at N, row counter=0, row_select=0, busy=1, grid_enable=0.
  - start while busy is ignored; no queueing.
- SETTLE (exactly one cycle): row_select is stable. The next edge:
  - captures cells into out_data;
  - sets out_valid=1;
  - sets out_last=(row==ROWS-1);
  - goes to SEND.
- SEND:
  - out_data, out_valid and out_last are held stable until handshake; out_valid is never withdrawn without handshake except by abort or reset.
  - Handshake on a non-last row: out_valid=0, row+1, row_select updated the same edge, go to SETTLE.
  - Handshake on the last row: out_valid=0, out_last=0, busy=0, grid_enable=1, done=1 for one cycle, row_select=0, go to IDLE.
- Timing:
  - start at edge N gives the first out_valid at edge N+1.
  - With out_ready tied high, each row costs 2 cycles. A full frame takes 2*ROWS cycles and done asserts at edge N+2*ROWS.
- Back-pressure: out_ready low stalls indefinitely in SEND with no data change. Later cells changes are not re-sampled, because the grid is frozen.
- abort=1 in any non-IDLE state: the next edge returns to IDLE with reset values on all outputs and no done. abort has priority over a simultaneous handshake. In IDLE, abort has priority over start.
- done and start on the same cycle (done is high in IDLE): start is accepted, and the new frame begins with no idle gap.
- Width rules:
  - row counter is $clog2(ROWS) bits; the last-row compare is against ROWS-1, so there is no wrap past ROWS-1.
  - out_data is COLS bits, copied unmodified from cells.

Test Plan:
- Blinker: reset, load grid row 4 = 8'h70 via set_cells (other rows 0), start, out_ready=1 → bytes 00,00,00,00,70,00,00,00. Required timing and flags:
  - out_last only on the 8th byte;
  - done at start edge+16;
  - grid_enable low throughout and the blinker not rotated mid-frame.
- Back-pressure: same pattern, out_ready low for 5 cycles on row 4 → out_data stays 8'h70 and out_valid stays 1 for all 5 stall cycles; frame completes correctly and done is delayed by 5 cycles.
- Abort: abort on row 3 during SEND with out_ready=1 in the same cycle → next cycle out_valid=0, busy=0, grid_enable=1, row_select=0, no done pulse; a new start then yields row 0 first.
- Reset mid-frame: drop reset_n between clock edges during row 5 → all outputs go to reset values immediately, without waiting for a clock edge; after release a frame restarts from row 0.
- Start while busy plus back-to-back frames:
  - extra start pulses mid-frame are ignored (exactly 8 bytes);
  - start asserted in the done cycle → second frame's first out_valid on the following edge, 16 bytes total, two done pulses.
- Full grid: all cells set → eight 8'hFF bytes. Then run with ROWS=4 → four bytes, out_last on the 4th, done at start+8.

Source files
------------

// File: rtl/silife_grid_reader.sv
// silife_grid_reader: freezes the silife grid, walks row_select over every row,
// captures each row after a one-cycle settle and hands it downstream over a
// valid/ready interface. A frame is always a snapshot of one generation.
module silife_grid_reader #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    grid_enable,
  output logic [$clog2(ROWS)-1:0] row_select,
  input  logic [COLS-1:0]         cells,
  output logic [COLS-1:0]         out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int            RW       = $clog2(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   row_reg, row_next;
  logic [COLS-1:0] data_reg, data_next;
  logic [COLS-1:0] sampled;
  logic            valid_reg, valid_next;
  logic            last_reg, last_next;
  logic            done_reg, done_next;
  logic            capture;
  logic            handshake;

  // The row is only sampled at the end of SETTLE, once row_select has had a full
  // cycle to propagate through the grid's row mux.
  assign capture   = (state_reg == SETTLE) && !abort;
  assign handshake = valid_reg && out_ready;

  // Per-column capture mux: load from the grid when capturing, otherwise hold.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi = gi + 1) begin : g_capture
      assign sampled[gi] = capture ? cells[gi] : data_reg[gi];
    end
  endgenerate

  // Next-state and next-output logic; abort overrides everything, including start.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    data_next  = sampled;
    valid_next = valid_reg;
    last_next  = last_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
          row_next   = '0;
        end
      end
      SETTLE: begin
        valid_next = 1'b1;
        last_next  = (row_reg == LAST_ROW);
        state_next = SEND;
      end
      SEND: begin
        if (handshake) begin
          valid_next = 1'b0;
          if (last_reg) begin
            // Final row taken: release the grid and signal frame completion.
            last_next  = 1'b0;
            done_next  = 1'b1;
            row_next   = '0;
            state_next = IDLE;
          end else begin
            row_next   = row_reg + RW'(1);
            state_next = SETTLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort) begin
      state_next = IDLE;
      row_next   = '0;
      data_next  = '0;
      valid_next = 1'b0;
      last_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign grid_enable = !busy;
  assign done        = done_reg;
  assign row_select  = row_reg;
  assign out_data    = data_reg;
  assign out_valid   = valid_reg;
  assign out_last    = last_reg;

endmodule
